// File: rtl/multicycle_control_fsm_if.sv
// multicycle_control_fsm_if: control and memory-handshake bundle between the sequencer and the datapath
interface multicycle_control_fsm_if #(parameter int CNT_W = 32);
  logic [6:0]       opcode_i;
  logic             mem_ready_i;
  logic             mem_req_o;
  logic             MemWrite_o;
  logic             AdrSrc_o;
  logic             IRWrite_o;
  logic             PCUpdate_o;
  logic             Branch_o;
  logic             RegWrite_o;
  logic [1:0]       ResultSrc_o;
  logic [1:0]       ALUSrcA_o;
  logic [1:0]       ALUSrcB_o;
  logic [1:0]       ALUOp_o;
  logic [2:0]       ImmSrc_o;
  logic [3:0]       state_o;
  logic             illegal_o;
  logic [CNT_W-1:0] instret_o;
  modport master (
    input  opcode_i, mem_ready_i,
    output mem_req_o, MemWrite_o, AdrSrc_o, IRWrite_o, PCUpdate_o, Branch_o, RegWrite_o,
           ResultSrc_o, ALUSrcA_o, ALUSrcB_o, ALUOp_o, ImmSrc_o, state_o, illegal_o, instret_o
  );
  modport slave (
    output opcode_i, mem_ready_i,
    input  mem_req_o, MemWrite_o, AdrSrc_o, IRWrite_o, PCUpdate_o, Branch_o, RegWrite_o,
           ResultSrc_o, ALUSrcA_o, ALUSrcB_o, ALUOp_o, ImmSrc_o, state_o, illegal_o, instret_o
  );
endinterface

// File: rtl/multicycle_control_fsm.sv
// multicycle_control_fsm: Moore sequencer for the multicycle RV32I datapath
module multicycle_control_fsm #(
  parameter int CNT_W      = 32,
  parameter int WAIT_LIMIT = 0
) (
  input logic                        clk_i,
  input logic                        rst_n_i,
  multicycle_control_fsm_if.master   bus
);
  typedef enum logic [3:0] {
    FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMREAD = 4'd3,
    MEMWB = 4'd4, MEMWRITE = 4'd5, EXECR = 4'd6, EXECI = 4'd7,
    ALUWB = 4'd8, BRANCH = 4'd9, JAL = 4'd10, JALR = 4'd11,
    LUI = 4'd12, AUIPC = 4'd13, LINK = 4'd14, TRAP = 4'd15
  } state_t;
  typedef struct packed {
    logic       mem_req;
    logic       mem_write;
    logic       adr_src;
    logic       pc_update;
    logic       branch;
    logic       reg_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
  } ctrl_t;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  state_t           state_q, state_d;
  ctrl_t            ctrl_q;
  logic [31:0]      wait_q, wait_d;
  logic [CNT_W-1:0] instret_q;
  logic             waiting, timeout, fetch_go;
  function automatic ctrl_t ctrl_of(state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      FETCH:    begin c.mem_req = 1'b1; c.result_src = 2'b10; c.alu_src_b = 2'b10; end
      DECODE:   begin c.alu_src_a = 2'b01; c.alu_src_b = 2'b01; end
      MEMADR:   begin c.alu_src_a = 2'b10; c.alu_src_b = 2'b01; end
      MEMREAD:  begin c.mem_req = 1'b1; c.adr_src = 1'b1; end
      MEMWB:    begin c.result_src = 2'b01; c.reg_write = 1'b1; end
      MEMWRITE: begin c.mem_req = 1'b1; c.mem_write = 1'b1; c.adr_src = 1'b1; end
      EXECR:    begin c.alu_src_a = 2'b10; c.alu_op = 2'b10; end
      EXECI:    begin c.alu_src_a = 2'b10; c.alu_src_b = 2'b01; c.alu_op = 2'b10; end
      ALUWB:    c.reg_write = 1'b1;
      BRANCH:   begin c.alu_src_a = 2'b10; c.alu_op = 2'b01; c.branch = 1'b1; end
      JAL:      begin c.pc_update = 1'b1; c.alu_src_a = 2'b01; c.alu_src_b = 2'b10; end
      JALR:     begin c.alu_src_a = 2'b10; c.alu_src_b = 2'b01; c.result_src = 2'b10; c.pc_update = 1'b1; end
      LUI:      begin c.alu_src_b = 2'b01; c.alu_op = 2'b11; end
      AUIPC:    begin c.alu_src_a = 2'b01; c.alu_src_b = 2'b01; end
      LINK:     begin c.alu_src_a = 2'b01; c.alu_src_b = 2'b10; end
      default:  c = '0;
    endcase
    return c;
  endfunction
  function automatic state_t decode_next(logic [6:0] op);
    state_t n;
    case (op)
      OP_LOAD, OP_STORE: n = MEMADR;
      OP_R:              n = EXECR;
      OP_I:              n = EXECI;
      OP_BR:             n = BRANCH;
      OP_JAL:            n = JAL;
      OP_JALR:           n = JALR;
      OP_LUI:            n = LUI;
      OP_AUIPC:          n = AUIPC;
      default:           n = TRAP;
    endcase
    return n;
  endfunction
  always_comb begin
    waiting = ctrl_q.mem_req && !bus.mem_ready_i;
    timeout = (WAIT_LIMIT > 0) && waiting && (wait_q + 32'd1 >= 32'(WAIT_LIMIT));
    state_d = state_q;
    case (state_q)
      FETCH:            state_d = bus.mem_ready_i ? DECODE : FETCH;
      DECODE:           state_d = decode_next(bus.opcode_i);
      MEMADR:           state_d = bus.opcode_i == OP_STORE ? MEMWRITE : MEMREAD;
      MEMREAD:          state_d = bus.mem_ready_i ? MEMWB : MEMREAD;
      MEMWRITE:         state_d = bus.mem_ready_i ? FETCH : MEMWRITE;
      JALR:             state_d = LINK;
      EXECR, EXECI, JAL, LUI, AUIPC, LINK: state_d = ALUWB;
      MEMWB, ALUWB, BRANCH: state_d = FETCH;
      default:          state_d = TRAP;
    endcase
    if (timeout) state_d = TRAP;
    wait_d = (state_d != state_q || bus.mem_ready_i) ? '0 : waiting ? wait_q + 32'd1 : wait_q;
  end
  // Control bundle is registered from the next state so outputs come straight off flops.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q   <= FETCH;
      ctrl_q    <= ctrl_of(FETCH);
      wait_q    <= '0;
      instret_q <= '0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_of(state_d);
      wait_q  <= wait_d;
      if (state_d == FETCH && state_q != FETCH) instret_q <= instret_q + CNT_W'(1);
    end
  end
  assign fetch_go        = state_q == FETCH && bus.mem_ready_i;
  assign bus.mem_req_o   = rst_n_i & ctrl_q.mem_req;
  assign bus.MemWrite_o  = rst_n_i & ctrl_q.mem_write;
  assign bus.AdrSrc_o    = ctrl_q.adr_src;
  assign bus.IRWrite_o   = rst_n_i & fetch_go;
  assign bus.PCUpdate_o  = rst_n_i & (ctrl_q.pc_update | fetch_go);
  assign bus.Branch_o    = rst_n_i & ctrl_q.branch;
  assign bus.RegWrite_o  = rst_n_i & ctrl_q.reg_write;
  assign bus.ResultSrc_o = ctrl_q.result_src;
  assign bus.ALUSrcA_o   = ctrl_q.alu_src_a;
  assign bus.ALUSrcB_o   = ctrl_q.alu_src_b;
  assign bus.ALUOp_o     = ctrl_q.alu_op;
  assign bus.ImmSrc_o    = state_q == DECODE ? (bus.opcode_i == OP_JAL ? 3'b100 : 3'b010) :
                           state_q == MEMADR ? (bus.opcode_i == OP_STORE ? 3'b001 : 3'b000) :
                           (state_q == LUI || state_q == AUIPC) ? 3'b011 : 3'b000;
  assign bus.state_o     = state_q;
  assign bus.illegal_o   = state_q == TRAP;
  assign bus.instret_o   = instret_q;
endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
- Main sequencer for the multicycle RV32I datapath. A single shared instruction/data memory, IR, OldPC and ALUOut registers, and one ALU are reused across cycles.
- Steps each instruction through fetch, decode, execute, memory and writeback states from the IR opcode.
- Drives all datapath mux selects and write enables.
- Handshakes with the shared memory port; flags illegal opcodes and counts retired instructions.

Parameters:
- CNT_W, 32, width of the retired-instruction counter.
- WAIT_LIMIT, 0, maximum cycles a memory request may wait for mem_ready_i before TRAP; 0 disables the timeout.

Ports:
- clk_i  in  1  clock.
- rst_n_i  in  1  synchronous active-low reset.
- opcode_i  in  7  IR[6:0]; stable from DECODE until the next FETCH.
- mem_ready_i  in  1  memory completes the current request this cycle.
- mem_req_o  out  1  memory request valid.
- MemWrite_o  out  1  request is a store (qualifies mem_req_o).
- AdrSrc_o  out  1  memory address select: 0 = PC, 1 = ALUOut.
- IRWrite_o  out  1  load IR and OldPC.
- PCUpdate_o  out  1  unconditional PC write.
- Branch_o  out  1  PC write qualified by the branch compare (combined outside).
- RegWrite_o  out  1  register file write.
- ResultSrc_o  out  2  00 = ALUOut, 01 = read data, 10 = ALUResult.
- ALUSrcA_o  out  2  00 = PC, 01 = OldPC, 10 = RD1.
- ALUSrcB_o  out  2  00 = RD2, 01 = ImmExt, 10 = constant 4.
- ALUOp_o  out  2  00 = add, 01 = subtract/compare, 10 = funct-decoded, 11 = pass B.
- ImmSrc_o  out  3  000 = I, 001 = S, 010 = B, 011 = U, 100 = J.
- state_o  out  4  current state encoding.
- illegal_o  out  1  sticky trap flag.
- instret_o  out  CNT_W  retired-instruction count.

Behaviour:
- Moore FSM: outputs decode from the registered state only; opcode_i is used for ImmSrc_o in DECODE/MEMADR and for next-state selection.
- Unlisted outputs are 0 in every state.
- State encodings: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECR 6, EXECI 7, ALUWB 8, BRANCH 9, JAL 10, JALR 11, LUI 12, AUIPC 13, LINK 14, TRAP 15.
- Reset, sampled on the clock edge with rst_n_i = 0:
  - state returns to FETCH, illegal_o = 0, instret_o = 0, wait counter = 0.
  - mem_req_o, MemWrite_o, IRWrite_o, PCUpdate_o, Branch_o and RegWrite_o are forced to 0 while rst_n_i = 0.
  - Reset mid-operation aborts the instruction with no further writes.
- FETCH:
  - outputs: mem_req=1, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10.
  - IRWrite=PCUpdate=mem_ready_i.
  - next state: DECODE when mem_ready_i = 1, else hold.
- DECODE:
  - outputs: ALUSrcA=01, ALUSrcB=01, ALUOp=00; ImmSrc=100 if opcode is JAL, else 010 (ALUOut <- OldPC+imm).
  - next state by opcode:
    - 0000011 or 0100011 -> MEMADR
    - 0110011 -> EXECR
    - 0010011 -> EXECI
    - 1100011 -> BRANCH
    - 1101111 -> JAL
    - 1100111 -> JALR
    - 0110111 -> LUI
    - 0010111 -> AUIPC
    - any other value -> TRAP
- MEMADR:
  - outputs: ALUSrcA=10, ALUSrcB=01, ALUOp=00; ImmSrc=001 for a store, else 000.
  - next state: MEMWRITE for a store, else MEMREAD.
- MEMREAD:
  - outputs: mem_req=1, AdrSrc=1.
  - next state: MEMWB on mem_ready_i, else hold.
- MEMWB: ResultSrc=01, RegWrite=1 -> FETCH.
- MEMWRITE:
  - outputs: mem_req=1, MemWrite=1, AdrSrc=1.
  - next state: FETCH on mem_ready_i, else hold.
- EXECR: ALUSrcA=10, ALUSrcB=00, ALUOp=10 -> ALUWB.
- EXECI: ALUSrcA=10, ALUSrcB=01, ImmSrc=000, ALUOp=10 -> ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1 -> FETCH.
- BRANCH: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1 -> FETCH.
- JAL: PCUpdate=1, ResultSrc=00, ALUSrcA=01, ALUSrcB=10, ALUOp=00 (ALUOut <- OldPC+4) -> ALUWB.
- JALR:
  - outputs: ALUSrcA=10, ALUSrcB=01, ImmSrc=000, ALUOp=00, ResultSrc=10, PCUpdate=1.
  - next state: LINK. rs1 is read before any rd write, so rd == rs1 is safe.
- LINK: ALUSrcA=01, ALUSrcB=10, ALUOp=00 -> ALUWB.
- LUI: ALUSrcB=01, ImmSrc=011, ALUOp=11 -> ALUWB.
- AUIPC: ALUSrcA=01, ALUSrcB=01, ImmSrc=011, ALUOp=00 -> ALUWB.
- TRAP: illegal_o=1; all enables are 0; state holds until reset.
- Retired count:
  - instret_o increments by 1 on every transition into FETCH from another state.
  - It wraps modulo 2^CNT_W.
- Wait timeout:
  - The wait counter increments each cycle mem_req_o=1 and mem_ready_i=0; it clears on mem_ready_i or on a state change.
  - If WAIT_LIMIT > 0 and the counter reaches WAIT_LIMIT, next state is TRAP.
  - mem_ready_i in the same cycle as the limit wins: normal transition.
- mem_ready_i is ignored in states other than FETCH, MEMREAD and MEMWRITE.

Test Plan:
- add (0110011), mem_ready_i=1 in fetch -> states 0,1,6,8,0; RegWrite=1 only in ALUWB; instret 0->1.
- lw (0000011), mem_ready_i low for 3 cycles in MEMREAD -> MEMREAD held 4 cycles with mem_req=1, AdrSrc=1; then MEMWB with ResultSrc=01, RegWrite=1.
- sw (0100011) -> MEMADR has ImmSrc=001; MEMWRITE has MemWrite=1; RegWrite is never 1; 4 cycles total; instret +1.
- jalr (1100111) -> states 0,1,11,14,8,0; PCUpdate=1 only in FETCH and JALR; ResultSrc=10 in JALR.
- opcode 1111111 -> TRAP; illegal_o=1 held for 20 cycles; rst_n_i=0 for one cycle -> FETCH, illegal_o=0, instret_o=0.
- WAIT_LIMIT=4, mem_ready_i=0 in FETCH -> TRAP after 4 wait cycles; reset asserted during MEMWRITE -> no further MemWrite, state FETCH.
